// File: rtl/axil_regfile_bridge.sv
// axil_regfile_bridge: AXI4-Lite slave driving the single-strobe regfile port of mem_regfile
module axil_regfile_bridge #(
  parameter int Naddr = 4,
  parameter int ADDR_W = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic [ADDR_W-1:0] regfile_addr,
  output logic [31:0]       regfile_din,
  output logic [3:0]        regfile_we,
  output logic              regfile_en,
  input  logic [31:0]       regfile_dout
);
  localparam logic [2:0] IDLE = 3'd0, WR = 3'd1, BRESP = 3'd2, RD = 3'd3, RWAIT = 3'd4, RRESP = 3'd5;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(1) << (Naddr + 2);
  logic [2:0] state_q, state_d, cnt_q, cnt_d;
  logic prio_wr_q, prio_wr_d, err_q, err_d;
  logic en_q, en_d, bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [3:0] we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] din_q, din_d, rdata_q, rdata_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic wr_pend, rd_pend, wr_grant, rd_grant, aw_ok, ar_ok;

  assign wr_pend = s_axil_awvalid && s_axil_wvalid;
  assign rd_pend = s_axil_arvalid;
  assign wr_grant = wr_pend && (!rd_pend || prio_wr_q);
  assign rd_grant = rd_pend && !wr_grant;
  assign aw_ok = {1'b0, s_axil_awaddr} < LIMIT;
  assign ar_ok = {1'b0, s_axil_araddr} < LIMIT;
  assign s_axil_awready = rstn && state_q == IDLE && wr_grant;
  assign s_axil_wready = s_axil_awready;
  assign s_axil_arready = rstn && state_q == IDLE && rd_grant;
  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata = rdata_q;
  assign s_axil_rresp = rresp_q;
  assign regfile_en = en_q;
  assign regfile_we = we_q;
  assign regfile_addr = addr_q;
  assign regfile_din = din_q;

  // next-state: grant, one-cycle strobe, latency count, response hold
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    prio_wr_d = prio_wr_q;
    err_d = err_q;
    en_d = 1'b0;
    we_d = 4'h0;
    addr_d = addr_q;
    din_d = din_q;
    bvalid_d = bvalid_q;
    bresp_d = bresp_q;
    rvalid_d = rvalid_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    case (state_q)
      IDLE: begin
        if (wr_grant) begin
          state_d = WR;
          prio_wr_d = 1'b0;
          err_d = !aw_ok;
          en_d = aw_ok;
          we_d = aw_ok ? s_axil_wstrb : 4'h0;
          addr_d = {s_axil_awaddr[ADDR_W-1:2], 2'b00};
          din_d = s_axil_wdata;
        end else if (rd_grant) begin
          state_d = RD;
          prio_wr_d = 1'b1;
          err_d = !ar_ok;
          en_d = ar_ok;
          addr_d = {s_axil_araddr[ADDR_W-1:2], 2'b00};
        end
      end
      WR: begin
        state_d = BRESP;
        bvalid_d = 1'b1;
        bresp_d = err_q ? 2'b10 : 2'b00;
      end
      BRESP: begin
        state_d = s_axil_bready ? IDLE : BRESP;
        bvalid_d = !s_axil_bready;
      end
      RD: begin
        state_d = RWAIT;
        cnt_d = 3'd0;
      end
      RWAIT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(RD_LATENCY - 1)) begin
          state_d = RRESP;
          rvalid_d = 1'b1;
          rdata_d = err_q ? 32'h0 : regfile_dout;
          rresp_d = err_q ? 2'b10 : 2'b00;
        end
      end
      RRESP: begin
        state_d = s_axil_rready ? IDLE : RRESP;
        rvalid_d = !s_axil_rready;
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= 3'd0;
      prio_wr_q <= 1'b1;
      err_q <= 1'b0;
      en_q <= 1'b0;
      we_q <= 4'h0;
      addr_q <= '0;
      din_q <= 32'h0;
      bvalid_q <= 1'b0;
      bresp_q <= 2'b00;
      rvalid_q <= 1'b0;
      rdata_q <= 32'h0;
      rresp_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      prio_wr_q <= prio_wr_d;
      err_q <= err_d;
      en_q <= en_d;
      we_q <= we_d;
      addr_q <= addr_d;
      din_q <= din_d;
      bvalid_q <= bvalid_d;
      bresp_q <= bresp_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end
endmodule
